// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and issue signals for the ALU reservation station.
//   master : dispatch stage / CDB / ALU side (drives requests, consumes issue)
//   slave  : the reservation station
// Tag value 0 is reserved as INVALID (no producer / no broadcast).
interface alu_reservation_station_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    // control
    logic             flush;
    // dispatch
    logic             disp_valid;
    logic             disp_ready;
    logic [3:0]       disp_alu_fun;
    logic [TAG_W-1:0] disp_rd_tag;
    logic [31:0]      disp_v1;
    logic [31:0]      disp_v2;
    logic             disp_v1_valid;
    logic             disp_v2_valid;
    logic [TAG_W-1:0] disp_q1;
    logic [TAG_W-1:0] disp_q2;
    // common data bus
    logic [31:0]      cdb_val;
    logic [TAG_W-1:0] cdb_tag;
    // issue to ALU
    logic             fu_done;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic             v1_valid;
    logic             v2_valid;
    logic [3:0]       alu_fun;
    logic [TAG_W-1:0] rd_tag;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output flush, disp_valid, disp_alu_fun, disp_rd_tag,
               disp_v1, disp_v2, disp_v1_valid, disp_v2_valid, disp_q1, disp_q2,
               cdb_val, cdb_tag, fu_done,
        input  disp_ready, v1, v2, v1_valid, v2_valid, alu_fun, rd_tag, occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_alu_fun, disp_rd_tag,
               disp_v1, disp_v2, disp_v1_valid, disp_v2_valid, disp_q1, disp_q2,
               cdb_val, cdb_tag, fu_done,
        output disp_ready, v1, v2, v1_valid, v2_valid, alu_fun, rd_tag, occupancy
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched instructions, captures missing
// operands from CDB broadcasts and issues the lowest-index ready entry.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_reservation_station_if.slave (dispatch, CDB, issue, occupancy)
// Issue outputs and disp_ready are combinational from registered state only.
module alu_reservation_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_reservation_station_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [TAG_W-1:0] TAG_INVALID = '0;

    // entry state
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] v1_rdy_q;
    logic [DEPTH-1:0] v2_rdy_q;
    logic [3:0]       fun_q [DEPTH];
    logic [TAG_W-1:0] rd_q  [DEPTH];
    logic [TAG_W-1:0] q1_q  [DEPTH];
    logic [TAG_W-1:0] q2_q  [DEPTH];
    logic [31:0]      v1_q  [DEPTH];
    logic [31:0]      v2_q  [DEPTH];
    logic [OCC_W-1:0] occ_q;

    logic             sel_vld_c;
    logic [IDX_W-1:0] sel_idx_c;
    logic [IDX_W-1:0] free_idx_c;
    logic             cdb_live_c;
    logic             disp_ready_c;
    logic             disp_fire_c;
    logic             issue_fire_c;
    logic             d1_rdy_c;
    logic             d2_rdy_c;
    logic [31:0]      d1_val_c;
    logic [31:0]      d2_val_c;

    // lowest-index eligible entry and lowest-index free entry
    always_comb begin
        sel_vld_c  = 1'b0;
        sel_idx_c  = '0;
        free_idx_c = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (busy_q[i] && v1_rdy_q[i] && v2_rdy_q[i]) begin
                sel_vld_c = 1'b1;
                sel_idx_c = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_idx_c = IDX_W'(i);
            end
        end
    end

    // handshakes and dispatch-time CDB bypass
    always_comb begin
        cdb_live_c   = (bus.cdb_tag != TAG_INVALID);
        disp_ready_c = (occ_q < OCC_W'(DEPTH));
        disp_fire_c  = bus.disp_valid && disp_ready_c;
        issue_fire_c = sel_vld_c && bus.fu_done;
        d1_rdy_c     = bus.disp_v1_valid || (cdb_live_c && (bus.disp_q1 == bus.cdb_tag));
        d2_rdy_c     = bus.disp_v2_valid || (cdb_live_c && (bus.disp_q2 == bus.cdb_tag));
        d1_val_c     = bus.disp_v1_valid ? bus.disp_v1 : bus.cdb_val;
        d2_val_c     = bus.disp_v2_valid ? bus.disp_v2 : bus.cdb_val;
    end

    // entry array: wakeup, issue retire, dispatch write, flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            v1_rdy_q <= '0;
            v2_rdy_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fun_q[i] <= '0;
                rd_q[i]  <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
            end
        end else if (bus.flush) begin
            busy_q <= '0;
            occ_q  <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (busy_q[i] && !v1_rdy_q[i] && cdb_live_c && (q1_q[i] == bus.cdb_tag)) begin
                    v1_q[i]     <= bus.cdb_val;
                    v1_rdy_q[i] <= 1'b1;
                end
                if (busy_q[i] && !v2_rdy_q[i] && cdb_live_c && (q2_q[i] == bus.cdb_tag)) begin
                    v2_q[i]     <= bus.cdb_val;
                    v2_rdy_q[i] <= 1'b1;
                end
                if (issue_fire_c && (sel_idx_c == IDX_W'(i))) begin
                    busy_q[i] <= 1'b0;
                end
                // free_idx_c points at a non-busy entry, so this never
                // collides with the wakeup or retire of the same entry
                if (disp_fire_c && (free_idx_c == IDX_W'(i))) begin
                    busy_q[i]   <= 1'b1;
                    fun_q[i]    <= bus.disp_alu_fun;
                    rd_q[i]     <= bus.disp_rd_tag;
                    q1_q[i]     <= bus.disp_q1;
                    q2_q[i]     <= bus.disp_q2;
                    v1_q[i]     <= d1_val_c;
                    v2_q[i]     <= d2_val_c;
                    v1_rdy_q[i] <= d1_rdy_c;
                    v2_rdy_q[i] <= d2_rdy_c;
                end
            end
            case ({disp_fire_c, issue_fire_c})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // issue port driven from the selected entry, zeros when idle
    always_comb begin
        bus.disp_ready = disp_ready_c;
        bus.occupancy  = occ_q;
        bus.v1_valid   = sel_vld_c;
        bus.v2_valid   = sel_vld_c;
        bus.v1         = '0;
        bus.v2         = '0;
        bus.alu_fun    = '0;
        bus.rd_tag     = TAG_INVALID;
        if (sel_vld_c) begin
            bus.v1      = v1_q[sel_idx_c];
            bus.v2      = v2_q[sel_idx_c];
            bus.alu_fun = fun_q[sel_idx_c];
            bus.rd_tag  = rd_q[sel_idx_c];
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios with
// literal expectations plus randomized traffic checked every cycle against a
// slot-level behavioural model.
module tb_alu_reservation_station;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_reservation_station_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_on = 1'b0;

    // model: one record per slot; operand is either a value or an awaited tag
    typedef struct {
        bit               busy;
        logic [3:0]       fun;
        logic [TAG_W-1:0] rd;
        logic [31:0]      v1;
        bit               r1;
        logic [TAG_W-1:0] q1;
        logic [31:0]      v2;
        bit               r2;
        logic [TAG_W-1:0] q2;
    } slot_t;

    slot_t m [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_sel();
        for (int i = 0; i < int'(DEPTH); i++)
            if (m[i].busy && m[i].r1 && m[i].r2) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (m[i].busy) c++;
        return c;
    endfunction

    // advance the model by one clock edge (or async reset)
    task automatic model_step();
        int s;
        int c;
        int f;
        if (!rst_n || bus.flush) begin
            for (int i = 0; i < int'(DEPTH); i++) m[i].busy = 1'b0;
            return;
        end
        s = m_sel();
        c = m_count();
        f = -1;
        for (int i = 0; i < int'(DEPTH); i++) if (!m[i].busy && f < 0) f = i;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (m[i].busy && bus.cdb_tag != 0) begin
                if (!m[i].r1 && m[i].q1 == bus.cdb_tag) begin m[i].v1 = bus.cdb_val; m[i].r1 = 1'b1; end
                if (!m[i].r2 && m[i].q2 == bus.cdb_tag) begin m[i].v2 = bus.cdb_val; m[i].r2 = 1'b1; end
            end
        end
        if (s >= 0 && bus.fu_done) m[s].busy = 1'b0;
        if (bus.disp_valid && c < int'(DEPTH)) begin
            m[f].busy = 1'b1;
            m[f].fun  = bus.disp_alu_fun;
            m[f].rd   = bus.disp_rd_tag;
            m[f].q1   = bus.disp_q1;
            m[f].q2   = bus.disp_q2;
            m[f].r1   = bus.disp_v1_valid || (bus.cdb_tag != 0 && bus.disp_q1 == bus.cdb_tag);
            m[f].r2   = bus.disp_v2_valid || (bus.cdb_tag != 0 && bus.disp_q2 == bus.cdb_tag);
            m[f].v1   = bus.disp_v1_valid ? bus.disp_v1 : bus.cdb_val;
            m[f].v2   = bus.disp_v2_valid ? bus.disp_v2 : bus.cdb_val;
        end
    endtask

    task automatic compare_model();
        int s = m_sel();
        int c = m_count();
        chk("occupancy", 32'(bus.occupancy), 32'(c));
        chk("disp_ready", 32'(bus.disp_ready), (c < int'(DEPTH)) ? 32'd1 : 32'd0);
        chk("v1_valid", 32'(bus.v1_valid), (s >= 0) ? 32'd1 : 32'd0);
        chk("v2_valid", 32'(bus.v2_valid), (s >= 0) ? 32'd1 : 32'd0);
        chk("v1", bus.v1, (s >= 0) ? m[s].v1 : 32'd0);
        chk("v2", bus.v2, (s >= 0) ? m[s].v2 : 32'd0);
        chk("alu_fun", 32'(bus.alu_fun), (s >= 0) ? 32'(m[s].fun) : 32'd0);
        chk("rd_tag", 32'(bus.rd_tag), (s >= 0) ? 32'(m[s].rd) : 32'd0);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) compare_model();
    end

    task automatic idle();
        bus.flush         = 1'b0;
        bus.disp_valid    = 1'b0;
        bus.disp_alu_fun  = '0;
        bus.disp_rd_tag   = '0;
        bus.disp_v1       = '0;
        bus.disp_v2       = '0;
        bus.disp_v1_valid = 1'b0;
        bus.disp_v2_valid = 1'b0;
        bus.disp_q1       = '0;
        bus.disp_q2       = '0;
        bus.cdb_val       = '0;
        bus.cdb_tag       = '0;
    endtask

    // start a new cycle: inputs idle, fu_done as given, outputs settled
    task automatic nxt(input bit fd);
        @(negedge clk);
        idle();
        bus.fu_done = fd;
        #1;
    endtask

    task automatic disp(input logic [3:0] fun, input logic [TAG_W-1:0] rd,
                        input bit a_ok, input logic [31:0] a, input logic [TAG_W-1:0] qa,
                        input bit b_ok, input logic [31:0] b, input logic [TAG_W-1:0] qb);
        bus.disp_valid    = 1'b1;
        bus.disp_alu_fun  = fun;
        bus.disp_rd_tag   = rd;
        bus.disp_v1_valid = a_ok;
        bus.disp_v1       = a;
        bus.disp_q1       = qa;
        bus.disp_v2_valid = b_ok;
        bus.disp_v2       = b;
        bus.disp_q2       = qb;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] v);
        bus.cdb_tag = t;
        bus.cdb_val = v;
    endtask

    initial begin
        idle();
        bus.fu_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // reset values, then a ready add issues the next cycle
        nxt(1'b1);
        chk("rst_occ", 32'(bus.occupancy), 32'd0);
        chk("rst_ready", 32'(bus.disp_ready), 32'd1);
        chk("rst_valid", 32'(bus.v1_valid), 32'd0);
        chk("rst_tag", 32'(bus.rd_tag), 32'd0);
        disp(4'd0, 5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
        nxt(1'b1);
        chk("add_v1", bus.v1, 32'd5);
        chk("add_v2", bus.v2, 32'd7);
        chk("add_valid", 32'({bus.v1_valid, bus.v2_valid}), 32'd3);
        chk("add_tag", 32'(bus.rd_tag), 32'd3);
        nxt(1'b1);
        chk("add_occ_after", 32'(bus.occupancy), 32'd0);
        chk("add_tag_after", 32'(bus.rd_tag), 32'd0);

        // wakeup by CDB; a non-matching tag does nothing
        disp(4'd2, 5'd5, 1'b1, 32'h10, 5'd0, 1'b0, 32'd0, 5'd6);
        nxt(1'b1);
        chk("wait_novalid", 32'(bus.v1_valid), 32'd0);
        nxt(1'b1);
        cdb(5'd7, 32'h55);
        nxt(1'b1);
        chk("wrong_tag", 32'(bus.v1_valid), 32'd0);
        cdb(5'd6, 32'h1234);
        nxt(1'b1);
        chk("wake_valid", 32'(bus.v1_valid), 32'd1);
        chk("wake_v1", bus.v1, 32'h10);
        chk("wake_v2", bus.v2, 32'h1234);
        chk("wake_tag", 32'(bus.rd_tag), 32'd5);

        // dispatch-time bypass
        nxt(1'b1);
        disp(4'd1, 5'd10, 1'b0, 32'd0, 5'd9, 1'b1, 32'd3, 5'd0);
        cdb(5'd9, 32'hAA);
        nxt(1'b1);
        chk("byp_v1", bus.v1, 32'hAA);
        chk("byp_tag", 32'(bus.rd_tag), 32'd10);

        // fill, drop a fifth dispatch, hold, then drain in order
        for (int k = 0; k < 4; k++) begin
            nxt(1'b0);
            disp(4'(k), 5'(16 + k), 1'b1, 32'(100 + k), 5'd0, 1'b1, 32'(200 + k), 5'd0);
        end
        nxt(1'b0);
        chk("full_ready", 32'(bus.disp_ready), 32'd0);
        chk("full_occ", 32'(bus.occupancy), 32'd4);
        chk("full_tag", 32'(bus.rd_tag), 32'd16);
        disp(4'd9, 5'd12, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
        nxt(1'b1);
        chk("hold_tag", 32'(bus.rd_tag), 32'd16);
        chk("hold_v1", bus.v1, 32'd100);
        chk("hold_occ", 32'(bus.occupancy), 32'd4);
        nxt(1'b0);
        chk("freed_ready", 32'(bus.disp_ready), 32'd1);
        chk("freed_occ", 32'(bus.occupancy), 32'd3);
        chk("next_tag", 32'(bus.rd_tag), 32'd17);
        for (int k = 1; k < 4; k++) begin
            nxt(1'b1);
            chk("drain_tag", 32'(bus.rd_tag), 32'(16 + k));
        end
        nxt(1'b1);
        chk("drop_occ", 32'(bus.occupancy), 32'd0);
        chk("drop_tag", 32'(bus.rd_tag), 32'd0);

        // one broadcast wakes index 0 and index 2
        nxt(1'b0); disp(4'd3, 5'd20, 1'b0, 32'd0, 5'd4, 1'b1, 32'd1, 5'd0);
        nxt(1'b0); disp(4'd3, 5'd21, 1'b0, 32'd0, 5'd13, 1'b1, 32'd2, 5'd0);
        nxt(1'b0); disp(4'd3, 5'd22, 1'b1, 32'd5, 5'd0, 1'b0, 32'd0, 5'd4);
        nxt(1'b1);
        chk("multi_wait", 32'(bus.v1_valid), 32'd0);
        cdb(5'd4, 32'h44);
        nxt(1'b1);
        chk("multi_first", 32'(bus.rd_tag), 32'd20);
        chk("multi_first_v1", bus.v1, 32'h44);
        nxt(1'b1);
        chk("multi_second", 32'(bus.rd_tag), 32'd22);
        chk("multi_second_v2", bus.v2, 32'h44);
        nxt(1'b1);
        chk("multi_left", 32'(bus.occupancy), 32'd1);
        cdb(5'd13, 32'h13);
        nxt(1'b1);
        chk("multi_last", 32'(bus.rd_tag), 32'd21);
        nxt(1'b0);

        // flush beats a simultaneous dispatch
        for (int k = 0; k < 3; k++) begin
            disp(4'd5, 5'(24 + k), 1'b0, 32'd0, 5'd15, 1'b1, 32'd0, 5'd0);
            nxt(1'b0);
        end
        chk("pre_flush_occ", 32'(bus.occupancy), 32'd3);
        bus.flush = 1'b1;
        disp(4'd6, 5'd23, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
        nxt(1'b0);
        chk("flush_occ", 32'(bus.occupancy), 32'd0);
        chk("flush_valid", 32'(bus.v1_valid), 32'd0);
        chk("flush_ready", 32'(bus.disp_ready), 32'd1);

        // async reset in the middle of a wakeup
        for (int k = 0; k < 3; k++) begin
            disp(4'd7, 5'(24 + k), 1'b0, 32'd0, 5'd14, 1'b1, 32'd9, 5'd0);
            nxt(1'b0);
        end
        cdb(5'd14, 32'h77);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_occ", 32'(bus.occupancy), 32'd0);
        chk("arst_valid", 32'(bus.v1_valid), 32'd0);
        chk("arst_tag", 32'(bus.rd_tag), 32'd0);
        chk("arst_v1", bus.v1, 32'd0);
        chk("arst_ready", 32'(bus.disp_ready), 32'd1);
        nxt(1'b1);
        rst_n = 1'b1;
        nxt(1'b1);
        chk("post_rst_valid", 32'(bus.v1_valid), 32'd0);
        chk("post_rst_occ", 32'(bus.occupancy), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            nxt($urandom_range(9, 0) < 7);
            if ($urandom_range(9, 0) < 6)
                disp(4'($urandom), 5'($urandom_range(31, 1)),
                     1'($urandom), $urandom, 5'($urandom_range(7, 1)),
                     1'($urandom), $urandom, 5'($urandom_range(7, 1)));
            cdb(5'($urandom_range(7, 0)), $urandom);
            bus.flush = ($urandom_range(49, 0) == 0);
        end
        nxt(1'b1);
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
